// File: rtl/unidade_controle.sv
// unidade_controle
// ----------------
// Main control unit of the single-cycle processor. The 2-bit Opcode and the
// 3-bit Funct are decoded combinationally, and every control output comes
// straight from a flop. The datapath therefore sees the controls exactly one
// clock after the instruction fields are presented.
//
// Ports
//   clock      in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high; clears every output to 0
//   Opcode     in   2  00 R-type, 01 I-type/memory, 10 branch, 11 jump/system
//   Funct      in   3  operation within the class
//   PCWrite    out  1  PC update enable
//   RegOrg1    out  1  read port 1 address: 0 rs, 1 rd
//   RegOrg2    out  1  read port 2 address: 0 rt, 1 rd
//   RegDst     out  1  write address: 0 rt, 1 rd
//   RegWrite   out  1  register file write enable
//   ALUSrc1    out  1  ALU A: 0 register, 1 PC
//   ALUSrc2    out  2  ALU B: 00 reg, 01 sext imm, 10 zext imm, 11 const 1
//   ALUOp      out  2  00 add, 01 sub, 10 from Funct, 11 pass B
//   JumpValue  out  2  00 PC+imm, 01 absolute imm, 10 register
//   Cond       out  1  1 = redirect gated by ALU zero
//   Jump       out  1  PC redirect request
//   MenWrite   out  1  data memory write
//   MenRead    out  1  data memory read
//   MenToReg   out  1  write-back source: 0 ALU, 1 memory
//
// Optional feature
//   UC_HALT_LATCH_EN: when this macro is defined, decoding halt (Opcode 11,
//   Funct 011) sets a sticky halted flag. While the flag is set, all outputs
//   are held at 0. Only reset clears the flag. When the macro is not defined,
//   halt affects only the cycle in which it is presented.

module unidade_controle (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] Opcode,
  input  logic [2:0] Funct,
  output logic       PCWrite,
  output logic       RegOrg1,
  output logic       RegOrg2,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrc1,
  output logic [1:0] ALUSrc2,
  output logic [1:0] ALUOp,
  output logic [1:0] JumpValue,
  output logic       Cond,
  output logic       Jump,
  output logic       MenWrite,
  output logic       MenRead,
  output logic       MenToReg
);

  // All control fields are kept in one packed word, so that reset and the
  // halt force can clear them together.
  typedef struct packed {
    logic       pc_write;
    logic       reg_org1;
    logic       reg_org2;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src1;
    logic [1:0] alu_src2;
    logic [1:0] alu_op;
    logic [1:0] jump_value;
    logic       cond;
    logic       jump;
    logic       men_write;
    logic       men_read;
    logic       men_to_reg;
  } ctrl_t;

  // Decode table. Every code that is not listed keeps the NOP value:
  // the PC advances and nothing else happens.
  function automatic ctrl_t decode(input logic [1:0] opcode,
                                   input logic [2:0] funct);
    ctrl_t c;
    c          = '0;
    c.pc_write = 1'b1;
    case (opcode)
      2'b00: begin
        if (funct != 3'b111) begin
          c.reg_dst   = 1'b1;
          c.reg_write = 1'b1;
          c.alu_op    = 2'b10;
        end else begin
          c.pc_write  = 1'b1;
        end
      end
      2'b01: begin
        case (funct)
          3'b000: begin                       // addi
            c.reg_write  = 1'b1;
            c.alu_src2   = 2'b01;
            c.alu_op     = 2'b00;
          end
          3'b001: begin                       // lw
            c.reg_write  = 1'b1;
            c.alu_src2   = 2'b01;
            c.alu_op     = 2'b00;
            c.men_read   = 1'b1;
            c.men_to_reg = 1'b1;
          end
          3'b010: begin                       // sw: data comes from rd
            c.reg_org2   = 1'b1;
            c.alu_src2   = 2'b01;
            c.alu_op     = 2'b00;
            c.men_write  = 1'b1;
          end
          3'b011: begin                       // ori: zero-extended imm
            c.reg_write  = 1'b1;
            c.alu_src2   = 2'b10;
            c.alu_op     = 2'b10;
          end
          default: begin
            c.pc_write   = 1'b1;
          end
        endcase
      end
      2'b10: begin
        // beq and bne share the same controls. The datapath uses Funct[0]
        // to choose the polarity of the zero flag.
        if ((funct == 3'b000) || (funct == 3'b001)) begin
          c.jump       = 1'b1;
          c.cond       = 1'b1;
          c.alu_op     = 2'b01;
          c.jump_value = 2'b00;
        end else begin
          c.pc_write   = 1'b1;
        end
      end
      2'b11: begin
        case (funct)
          3'b000: begin                       // j
            c.jump       = 1'b1;
            c.jump_value = 2'b01;
          end
          3'b001: begin                       // jal: link = PC + 1
            c.jump       = 1'b1;
            c.jump_value = 2'b01;
            c.reg_write  = 1'b1;
            c.alu_src1   = 1'b1;
            c.alu_src2   = 2'b11;
            c.alu_op     = 2'b00;
          end
          3'b010: begin                       // jr: target from rd
            c.jump       = 1'b1;
            c.jump_value = 2'b10;
            c.reg_org1   = 1'b1;
          end
          3'b011: begin                       // halt: freeze the PC
            c            = '0;
          end
          default: begin
            c.pc_write   = 1'b1;
          end
        endcase
      end
      default: begin
        c.pc_write = 1'b1;
      end
    endcase
    return c;
  endfunction

  ctrl_t ctrl_next_s;
  ctrl_t ctrl_r;

`ifdef UC_HALT_LATCH_EN
  logic halt_s;
  logic halted_r;
  logic halted_next_s;

  // Detect the halt instruction in the current fields.
  always_comb begin
    halt_s = 1'b0;
    if ((Opcode == 2'b11) && (Funct == 3'b011)) begin
      halt_s = 1'b1;
    end else begin
      halt_s = 1'b0;
    end
  end

  // Halted flag next state: the flag is sticky once halt is seen.
  always_comb begin
    halted_next_s = halted_r;
    if (halt_s) begin
      halted_next_s = 1'b1;
    end else begin
      halted_next_s = halted_r;
    end
  end

  // Halted flag register; only reset clears it.
  always_ff @(posedge clock) begin
    if (reset) begin
      halted_r <= 1'b0;
    end else begin
      halted_r <= halted_next_s;
    end
  end

  // Next controls: decode, or all zero while halted.
  always_comb begin
    ctrl_next_s = '0;
    if (halted_r) begin
      ctrl_next_s = '0;
    end else begin
      ctrl_next_s = decode(Opcode, Funct);
    end
  end
`else
  // Next controls: plain decode of the current instruction fields.
  always_comb begin
    ctrl_next_s = decode(Opcode, Funct);
  end
`endif

  // Output register; reset takes priority over decode.
  always_ff @(posedge clock) begin
    if (reset) begin
      ctrl_r <= '0;
    end else begin
      ctrl_r <= ctrl_next_s;
    end
  end

  assign PCWrite   = ctrl_r.pc_write;
  assign RegOrg1   = ctrl_r.reg_org1;
  assign RegOrg2   = ctrl_r.reg_org2;
  assign RegDst    = ctrl_r.reg_dst;
  assign RegWrite  = ctrl_r.reg_write;
  assign ALUSrc1   = ctrl_r.alu_src1;
  assign ALUSrc2   = ctrl_r.alu_src2;
  assign ALUOp     = ctrl_r.alu_op;
  assign JumpValue = ctrl_r.jump_value;
  assign Cond      = ctrl_r.cond;
  assign Jump      = ctrl_r.jump;
  assign MenWrite  = ctrl_r.men_write;
  assign MenRead   = ctrl_r.men_read;
  assign MenToReg  = ctrl_r.men_to_reg;

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle. Outputs are compared as one 17-bit word:
// {PCWrite,RegOrg1,RegOrg2,RegDst,RegWrite,ALUSrc1,ALUSrc2,ALUOp,JumpValue,
//  Cond,Jump,MenWrite,MenRead,MenToReg}

// Invariants on the registered controls, checked on every falling edge.
module unidade_controle_chk (
  input logic       clock,
  input logic [1:0] JumpValue,
  input logic       Jump,
  input logic       MenWrite,
  input logic       MenRead,
  input logic       MenToReg
);
  // Check the invariants away from the active edge.
  always @(negedge clock) begin
    assert (!(MenRead && MenWrite)) else $error("FAIL inv_rw: both memory strobes set");
    assert (!MenToReg || MenRead) else $error("FAIL inv_mtr: MenToReg without MenRead");
    assert (!(Jump && MenWrite)) else $error("FAIL inv_jw: Jump with MenWrite");
    assert (JumpValue != 2'b11) else $error("FAIL inv_jv: JumpValue 11 produced");
  end
endmodule

module tb_unidade_controle;
  logic       clock;
  logic       reset;
  logic [1:0] Opcode;
  logic [2:0] Funct;
  logic       PCWrite, RegOrg1, RegOrg2, RegDst, RegWrite, ALUSrc1;
  logic [1:0] ALUSrc2, ALUOp, JumpValue;
  logic       Cond, Jump, MenWrite, MenRead, MenToReg;

  int vectors;
  int miscompares;

  //                                P A B D W S ss oo jj C J w r t
  localparam logic [16:0] E_NOP  = 17'b1_0_0_0_0_0_00_00_00_0_0_0_0_0;
  localparam logic [16:0] E_ZERO = 17'b0_0_0_0_0_0_00_00_00_0_0_0_0_0;
  localparam logic [16:0] E_R    = 17'b1_0_0_1_1_0_00_10_00_0_0_0_0_0;
  localparam logic [16:0] E_ADDI = 17'b1_0_0_0_1_0_01_00_00_0_0_0_0_0;
  localparam logic [16:0] E_LW   = 17'b1_0_0_0_1_0_01_00_00_0_0_0_1_1;
  localparam logic [16:0] E_SW   = 17'b1_0_1_0_0_0_01_00_00_0_0_1_0_0;
  localparam logic [16:0] E_ORI  = 17'b1_0_0_0_1_0_10_10_00_0_0_0_0_0;
  localparam logic [16:0] E_BR   = 17'b1_0_0_0_0_0_00_01_00_1_1_0_0_0;
  localparam logic [16:0] E_J    = 17'b1_0_0_0_0_0_00_00_01_0_1_0_0_0;
  localparam logic [16:0] E_JAL  = 17'b1_0_0_0_1_1_11_00_01_0_1_0_0_0;
  localparam logic [16:0] E_JR   = 17'b1_1_0_0_0_0_00_00_10_0_1_0_0_0;

  unidade_controle dut (
    .clock(clock), .reset(reset), .Opcode(Opcode), .Funct(Funct),
    .PCWrite(PCWrite), .RegOrg1(RegOrg1), .RegOrg2(RegOrg2), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2), .ALUOp(ALUOp),
    .JumpValue(JumpValue), .Cond(Cond), .Jump(Jump), .MenWrite(MenWrite),
    .MenRead(MenRead), .MenToReg(MenToReg)
  );

  unidade_controle_chk chk (
    .clock(clock), .JumpValue(JumpValue), .Jump(Jump),
    .MenWrite(MenWrite), .MenRead(MenRead), .MenToReg(MenToReg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hand-written decode table, indexed by {Opcode, Funct}.
  function automatic logic [16:0] table_exp(input int idx);
    case (idx)
      0, 1, 2, 3, 4, 5, 6: table_exp = E_R;
      8:  table_exp = E_ADDI;
      9:  table_exp = E_LW;
      10: table_exp = E_SW;
      11: table_exp = E_ORI;
      16, 17: table_exp = E_BR;
      24: table_exp = E_J;
      25: table_exp = E_JAL;
      26: table_exp = E_JR;
      27: table_exp = E_ZERO;
      default: table_exp = E_NOP;
    endcase
  endfunction

  // Drive the fields, let one rising edge pass, and compare 1 ns later.
  task automatic step(input string tag, input logic rst, input logic [1:0] op,
                      input logic [2:0] fn, input logic [16:0] exp);
    logic [16:0] obs;
    reset  = rst;
    Opcode = op;
    Funct  = fn;
    @(posedge clock);
    #1;
    obs = {PCWrite, RegOrg1, RegOrg2, RegDst, RegWrite, ALUSrc1, ALUSrc2,
           ALUOp, JumpValue, Cond, Jump, MenWrite, MenRead, MenToReg};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    Opcode      = 2'b01;
    Funct       = 3'b001;

    // Reset held for two edges while lw is presented.
    step("reset_0", 1'b1, 2'b01, 3'b001, E_ZERO);
    step("reset_1", 1'b1, 2'b01, 3'b001, E_ZERO);
    step("lw_after_reset", 1'b0, 2'b01, 3'b001, E_LW);

    // Sweep all 32 codes, excluding halt, which is checked separately.
    for (int i = 0; i < 32; i++) begin
      if (i != 27) begin
        step($sformatf("sweep_%0d", i), 1'b0, i[4:3], i[2:0], table_exp(i));
      end
    end

    // Directed cases.
    step("bne",  1'b0, 2'b10, 3'b001, E_BR);
    step("jal",  1'b0, 2'b11, 3'b001, E_JAL);
    step("sw",   1'b0, 2'b01, 3'b010, E_SW);
    step("rst_prio", 1'b1, 2'b11, 3'b001, E_ZERO);
    step("ori_after_rst", 1'b0, 2'b01, 3'b011, E_ORI);

    // Halt followed by an R-type instruction.
    step("halt", 1'b0, 2'b11, 3'b011, E_ZERO);
`ifdef UC_HALT_LATCH_EN
    step("halted_r", 1'b0, 2'b00, 3'b000, E_ZERO);
    step("halted_lw", 1'b0, 2'b01, 3'b001, E_ZERO);
    step("halted_reset", 1'b1, 2'b00, 3'b000, E_ZERO);
`else
    step("after_halt_r", 1'b0, 2'b00, 3'b000, E_R);
    step("after_halt_lw", 1'b0, 2'b01, 3'b001, E_LW);
    step("reset_again", 1'b1, 2'b00, 3'b000, E_ZERO);
`endif
    step("r_after_reset", 1'b0, 2'b00, 3'b000, E_R);
    step("jr", 1'b0, 2'b11, 3'b010, E_JR);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
